// File: rtl/gshare_predictor.sv
// Gshare branch predictor: global-history-XOR-PC indexed PHT of 2-bit
// counters plus a direct-mapped BTB. Lookup is combinational. Resolution
// updates train the PHT and BTB and repair the speculative history.
module gshare_predictor #(
    parameter int XLEN      = 32,
    parameter int GHR_W     = 4,
    parameter int IDX_W     = 6,
    parameter int BTB_IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_pc,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             res_valid,
    input  logic [XLEN-1:0]  res_pc,
    input  logic [XLEN-1:0]  res_target,
    input  logic             res_taken,
    input  logic             res_is_cond,
    input  logic             res_mispredict,
    input  logic [GHR_W-1:0] res_ghr,
    output logic [31:0]      mispredict_count
);
    localparam int PHT_N = 1 << IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = XLEN - BTB_IDX_W - 2;

    logic [GHR_W-1:0] spec_ghr;
    logic [1:0]       pht        [PHT_N];
    logic             btb_valid  [BTB_N];
    logic [TAG_W-1:0] btb_tag    [BTB_N];
    logic [XLEN-1:0]  btb_target [BTB_N];
    logic             btb_is_cond[BTB_N];

    logic [IDX_W-1:0]     fetch_pht_idx;
    logic [BTB_IDX_W-1:0] fetch_btb_idx;
    logic [TAG_W-1:0]     fetch_tag;
    logic                 fetch_is_cond;
    logic [IDX_W-1:0]     res_pht_idx;
    logic [BTB_IDX_W-1:0] res_btb_idx;
    logic [TAG_W-1:0]     res_tag;
    logic                 recover;

    // PC bits [1:0] never address anything; instructions are word aligned.
    logic unused_res_pc_lo;
    assign unused_res_pc_lo = ^res_pc[1:0];

    // Combinational lookup against the registered (pre-update) state.
    always_comb begin
        fetch_pht_idx = fetch_pc[IDX_W+1:2] ^ IDX_W'(spec_ghr);
        fetch_btb_idx = fetch_pc[BTB_IDX_W+1:2];
        fetch_tag     = fetch_pc[XLEN-1:BTB_IDX_W+2];
        fetch_is_cond = btb_is_cond[fetch_btb_idx];
        pred_valid    = btb_valid[fetch_btb_idx] && (btb_tag[fetch_btb_idx] == fetch_tag);
        pred_taken    = pred_valid && (!fetch_is_cond || pht[fetch_pht_idx][1]);
        pred_pc       = pred_taken ? btb_target[fetch_btb_idx] : fetch_pc + XLEN'(4);
        pred_ghr      = spec_ghr;
        res_pht_idx   = res_pc[IDX_W+1:2] ^ IDX_W'(res_ghr);
        res_btb_idx   = res_pc[BTB_IDX_W+1:2];
        res_tag       = res_pc[XLEN-1:BTB_IDX_W+2];
        recover       = res_valid && res_mispredict;
    end

    // Speculative history: recovery from EX overrides the fetch-side shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_ghr <= '0;
        end else if (recover) begin
            spec_ghr <= res_is_cond ? GHR_W'({res_ghr, res_taken}) : res_ghr;
        end else if (fetch_valid && pred_valid && fetch_is_cond) begin
            spec_ghr <= GHR_W'({spec_ghr, pred_taken});
        end
    end

    // PHT training with the history snapshot the branch was predicted with.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
        end else if (res_valid && res_is_cond) begin
            if (res_taken && pht[res_pht_idx] != 2'b11)
                pht[res_pht_idx] <= pht[res_pht_idx] + 2'b01;
            else if (!res_taken && pht[res_pht_idx] != 2'b00)
                pht[res_pht_idx] <= pht[res_pht_idx] - 2'b01;
        end
    end

    // BTB fill on every taken control-flow resolution.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid[i]   <= 1'b0;
                btb_tag[i]     <= '0;
                btb_target[i]  <= '0;
                btb_is_cond[i] <= 1'b0;
            end
        end else if (res_valid && res_taken) begin
            btb_valid[res_btb_idx]   <= 1'b1;
            btb_tag[res_btb_idx]     <= res_tag;
            btb_target[res_btb_idx]  <= res_target;
            btb_is_cond[res_btb_idx] <= res_is_cond;
        end
    end

    // Saturating mispredict counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_count <= '0;
        end else if (recover && mispredict_count != 32'hFFFF_FFFF) begin
            mispredict_count <= mispredict_count + 32'd1;
        end
    end
endmodule
